reemashivva_fifo: RTL and testbench
===================================

Name: reemashivva_fifo

Overview:
- Synchronous FIFO with WIDTH-bit entries and DEPTH-entry storage.
- Writes and reads run at different fixed rates, derived from a single clock `clk` by an internal rate divider that produces enable ticks. The divider does not generate derived clocks.
- Used as a rate-matching buffer between a fast producer and a slow consumer on the one `clk` domain.

Parameters:
- WIDTH, 4, data width in bits (≥1).
- DEPTH, 8, number of entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_rq  input  1  write request; level-sensitive, sampled on write ticks.
- rd_rq  input  1  read request; level-sensitive, sampled on read ticks.
- wdata  input  WIDTH  write data, sampled when a write is accepted.
- rdata  output  WIDTH  registered read data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Rate divider: free-running 2-bit counter `cnt`, reset to 0, increments every clk.
  - w_tick = cnt[0] (true when cnt = 1 or 3): one write opportunity every 2 clk cycles.
  - r_tick = (cnt == 3): one read opportunity every 4 clk cycles.
  - The first w_tick is the 2nd rising edge after reset release; the first r_tick is the 4th.
- Pointers: wptr and rptr, each $clog2(DEPTH)+1 bits (the extra MSB is a wrap bit). Both reset to 0.
  - Address is the low $clog2(DEPTH) bits.
  - Pointers wrap naturally modulo 2·DEPTH.
- Flags (combinational from the registered pointers):
  - empty = (wptr == rptr).
  - full = (address bits equal) AND (wrap bits differ).
- Write accept = w_tick & wr_rq & !full.
  - On accept: mem[wptr addr] <= wdata; wptr <= wptr + 1.
  - Otherwise no state change; a write while full is dropped silently.
- Read accept = r_tick & rd_rq & !empty.
  - On accept: rdata <= mem[rptr addr]; rptr <= rptr + 1.
  - rdata holds its last value otherwise.
  - Latency: data appears on rdata the cycle after the accepting edge.
- Simultaneous read and write accepts on the same edge (cnt = 3): both take effect.
  - Flags are evaluated from the pre-edge pointers.
  - Write while full is still blocked even when a read occurs on the same edge.
  - Read while empty is still blocked even when a write occurs on the same edge (no fall-through).
- Reset (asynchronous, any time including mid-transfer):
  - cnt = 0, wptr = rptr = 0, rdata = 0, empty = 1, full = 0.
  - Memory contents are not reset and are don't-care.
  - Operation resumes from the empty state on release.
- Occupancy is never negative and never exceeds DEPTH.
- X on wr_rq/rd_rq is not permitted during operation.

Decomposition:
- Shared package `reemashivva_fifo_pkg`:
  - localparam function for pointer width (clog2(DEPTH)+1).
  - divider constants: W_PERIOD = 2, R_PERIOD = 4.
- Sub-module `fifo_rate_divider` (clk, rst_n → w_tick, r_tick): counter plus tick decode.
- FIFO storage, pointers and flags stay in the top module.

Test Plan (WIDTH = 4, DEPTH = 8):
- Reset: assert rst_n = 0 mid-operation with 3 entries stored → immediately empty = 1, full = 0, rdata = 0; after release, no read succeeds until a new write.
- Fill: wr_rq = 1, rd_rq = 0, wdata = 1,2,…,9 on successive write ticks.
  - full rises after the 8th accept (16 clk after release); value 9 is dropped; empty = 0.
- Drain: rd_rq = 1, wr_rq = 0 after fill.
  - rdata = 1,2,…,8 on successive read ticks (every 4 clk).
  - empty = 1 after the 8th read; further reads leave rdata = 8.
- Wrap-around: write 5, read 5, then write 6 values A..F and read 6.
  - Order is preserved across the address wrap; full never asserts.
- Concurrent: wr_rq = rd_rq = 1 from empty with random data.
  - Occupancy grows by 1 per 4 clk; full asserts after about 32 clk.
  - Thereafter the read-data sequence matches a reference queue model; no write is accepted while full.
- Empty read: rd_rq = 1 with FIFO empty for 20 clk → rptr is unchanged, rdata is unchanged, empty stays 1.

Source files
------------

// File: rtl/reemashivva_fifo_pkg.sv
// Shared constants and helpers for the rate-matching FIFO.
package reemashivva_fifo_pkg;

   localparam int W_PERIOD = 2;
   localparam int R_PERIOD = 4;

   // Pointer carries one extra wrap bit above the address.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/reemashivva_fifo_if.sv
// Producer/consumer bundle for the rate-matching FIFO.
interface reemashivva_fifo_if #(
   parameter int WIDTH = 4
);

   logic             wr_rq;
   logic             rd_rq;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             full;
   logic             empty;

   modport master (
      output wr_rq, rd_rq, wdata,
      input  rdata, full, empty
   );

   modport slave (
      input  wr_rq, rd_rq, wdata,
      output rdata, full, empty
   );

endinterface

// File: rtl/reemashivva_fifo_rate_divider.sv
// Free-running counter that decodes write and read enable ticks.
module fifo_rate_divider
   import reemashivva_fifo_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   output logic w_tick_o,
   output logic r_tick_o
);

   localparam int CW = $clog2(R_PERIOD);
   localparam int WW = $clog2(W_PERIOD);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Ticks fire on the last count of each period.
   assign w_tick_o = &cnt_q[WW-1:0];
   assign r_tick_o = &cnt_q;

endmodule

// File: rtl/reemashivva_fifo.sv
// Synchronous FIFO with divided write/read rates on one clock.
module reemashivva_fifo
   import reemashivva_fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   reemashivva_fifo_if.slave  bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic             w_tick;
   logic             r_tick;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full_w;
   logic             empty_w;
   logic             wr_acc;
   logic             rd_acc;

   fifo_rate_divider u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_tick_o (w_tick),
      .r_tick_o (r_tick)
   );

   assign empty_w = (wptr_q == rptr_q);
   assign full_w  = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
                 && (wptr_q[AW] != rptr_q[AW]);

   // Flags come from pre-edge pointers: no fall-through, no write-through.
   assign wr_acc = w_tick & bus.wr_rq & ~full_w;
   assign rd_acc = r_tick & bus.rd_rq & ~empty_w;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      rdata_d = rdata_q;
      if (wr_acc) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (rd_acc) begin
         rptr_d  = rptr_q + PW'(1);
         rdata_d = mem_q[rptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         rdata_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wptr_q[AW-1:0]] <= bus.wdata;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.full  = full_w;
   assign bus.empty = empty_w;

endmodule

// File: tb/tb_reemashivva_fifo.sv
// Scoreboard bench for the rate-matching FIFO.
module tb_reemashivva_fifo;
   import reemashivva_fifo_pkg::*;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   reemashivva_fifo_if #(.WIDTH(WIDTH)) bus ();

   reemashivva_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] mq    [$];
   logic [WIDTH-1:0] exp_q [$];
   int               mcnt;
   int               m_reads;
   logic [WIDTH-1:0] m_rdata;
   int               full_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference queue model; read results go to the scoreboard queue.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         mcnt    = 0;
         m_reads = 0;
         m_rdata = '0;
      end else begin
         bit wt, rt, wa, ra;
         wt = (mcnt % W_PERIOD) == W_PERIOD - 1;
         rt = (mcnt % R_PERIOD) == R_PERIOD - 1;
         wa = wt && bus.wr_rq && (mq.size() < DEPTH);
         ra = rt && bus.rd_rq && (mq.size() > 0);
         if (ra) begin
            m_rdata = mq.pop_front();
            exp_q.push_back(m_rdata);
            m_reads++;
         end
         if (wa) mq.push_back(bus.wdata);
         mcnt = (mcnt + 1) % R_PERIOD;
      end
   end

   // Monitor: flags every cycle, data whenever a read completed.
   always @(negedge clk) begin
      chk("empty_flag", 32'(bus.empty), 32'(mq.size() == 0));
      chk("full_flag", 32'(bus.full), 32'(mq.size() == DEPTH));
      if (bus.full) full_cnt++;
      if (exp_q.size() > 0) begin
         chk("rdata_sb", 32'(bus.rdata), 32'(exp_q.pop_front()));
      end else begin
         chk("rdata_hold", 32'(bus.rdata), 32'(m_rdata));
      end
   end

   initial begin
      int f0;
      logic [WIDTH-1:0] last;
      bus.wr_rq = 1'b0;
      bus.rd_rq = 1'b0;
      bus.wdata = '0;
      #1 rst_n = 1'b0;
      tick(2);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      rst_n = 1'b1;

      // Fill: 1..9, the ninth is dropped
      bus.wr_rq = 1'b1;
      for (int v = 1; v <= 9; v++) begin
         bus.wdata = WIDTH'(v);
         tick(2);
         if (v == 7) chk("fill_notfull14", 32'(bus.full), 32'd0);
         if (v == 8) begin
            chk("fill_full16", 32'(bus.full), 32'd1);
            chk("fill_notempty", 32'(bus.empty), 32'd0);
         end
      end
      chk("fill_full_drop", 32'(bus.full), 32'd1);

      // Drain
      bus.wr_rq = 1'b0;
      bus.rd_rq = 1'b1;
      tick(2);
      chk("drain_first", 32'(bus.rdata), 32'd1);
      tick(30);
      chk("drain_last", 32'(bus.rdata), 32'd8);
      chk("drain_empty", 32'(bus.empty), 32'd1);
      tick(8);
      chk("drain_hold", 32'(bus.rdata), 32'd8);

      // Wrap-around
      f0 = full_cnt;
      bus.rd_rq = 1'b0;
      bus.wr_rq = 1'b1;
      for (int v = 3; v <= 7; v++) begin
         bus.wdata = WIDTH'(v);
         tick(2);
      end
      bus.wr_rq = 1'b0;
      bus.rd_rq = 1'b1;
      tick(20);
      chk("wrap_first5", 32'(bus.rdata), 32'd7);
      bus.rd_rq = 1'b0;
      bus.wr_rq = 1'b1;
      for (int v = 10; v <= 15; v++) begin
         bus.wdata = WIDTH'(v);
         tick(2);
      end
      bus.wr_rq = 1'b0;
      bus.rd_rq = 1'b1;
      tick(24);
      chk("wrap_last6", 32'(bus.rdata), 32'hF);
      chk("wrap_empty", 32'(bus.empty), 32'd1);
      chk("wrap_nofull", 32'(full_cnt - f0), 32'd0);

      // Concurrent from empty
      f0 = full_cnt;
      bus.wr_rq = 1'b1;
      bus.rd_rq = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.wdata = WIDTH'($urandom_range(0, 15));
         tick(2);
      end
      chk("conc_full_seen", 32'(full_cnt > f0), 32'd1);
      bus.wr_rq = 1'b0;
      tick(40);
      chk("conc_drained", 32'(bus.empty), 32'd1);

      // Empty read
      last = m_rdata;
      tick(20);
      chk("er_rdata", 32'(bus.rdata), 32'(last));
      chk("er_empty", 32'(bus.empty), 32'd1);
      chk("er_rptr", 32'(dut.rptr_q), 32'(m_reads % (2 * DEPTH)));

      // Reset mid-operation with 3 entries stored
      bus.rd_rq = 1'b0;
      bus.wr_rq = 1'b1;
      for (int v = 1; v <= 3; v++) begin
         bus.wdata = WIDTH'(v + 8);
         tick(2);
      end
      chk("pre_rst_notempty", 32'(bus.empty), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_empty", 32'(bus.empty), 32'd1);
      chk("mid_rst_full", 32'(bus.full), 32'd0);
      chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
      bus.wr_rq = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.rd_rq = 1'b1;
      tick(12);
      chk("post_rst_noread", 32'(bus.rdata), 32'd0);
      chk("post_rst_empty", 32'(bus.empty), 32'd1);
      bus.rd_rq = 1'b0;
      bus.wr_rq = 1'b1;
      bus.wdata = 4'h5;
      tick(2);
      bus.wr_rq = 1'b0;
      bus.rd_rq = 1'b1;
      tick(4);
      chk("post_rst_read", 32'(bus.rdata), 32'h5);
      chk("post_rst_empty2", 32'(bus.empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
